// File: rtl/imem_dump_reader_pkg.sv
// ============================================================================
// imem_dump_reader_pkg : shared state encodings and IM defaults for the dump reader
// Rev 1.0
// ============================================================================
`default_nettype none

package imem_dump_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int IM_DATA_W  = 32;
  localparam int IM_ADDR_W  = 32;

endpackage

`default_nettype wire

// File: rtl/imem_dump_fifo.sv
// ============================================================================
// imem_dump_fifo : synchronous skid FIFO holding {addr, data, last} return beats
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_dump_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]       count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q, count_d;
  logic             w_push, w_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign count_d = count_q + CW'(w_push) - CW'(w_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (w_pop) rd_q <= rd_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/imem_dump_reader.sv
// ============================================================================
// imem_dump_reader : streams word_count IM words from base_addr out on valid/ready
// Optional running checksum enabled by defining IMEM_DUMP_CHECKSUM_EN. Rev 1.0
// ============================================================================
`default_nettype none

module imem_dump_reader
  import imem_dump_reader_pkg::*;
#(
  parameter int DATA_W     = IM_DATA_W,
  parameter int ADDR_W     = IM_ADDR_W,
  parameter int CNT_W      = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [CNT_W-1:0]  word_count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              im_re_o,
  output logic [ADDR_W-1:0] im_raddr_o,
  input  logic [DATA_W-1:0] im_rdata_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic              dump_last_o,
  output logic [DATA_W-1:0] checksum_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_W + DATA_W + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q;
  logic [CNT_W-1:0]      count_q, issued_q;
  logic [RD_LAT-1:0]     tag_vld_q, tag_last_q;
  logic [ADDR_W-1:0]     tag_addr_q [RD_LAT];
  logic [CW-1:0]         fifo_count, inflight;
  logic                  fifo_full, fifo_empty;
  logic [FW-1:0]         fifo_rdata;
  logic                  w_credit, w_last_issue, w_pop, w_accept;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_vld_q[i]);
  end

  // Credits cover FIFO occupancy plus every read still in the return pipe.
  assign w_credit     = !fifo_full && (((CW+1)'(fifo_count) + (CW+1)'(inflight)) < DEPTH_C);
  assign w_last_issue = (issued_q == (count_q - CNT_W'(1)));
  assign im_raddr_o   = base_q + (ADDR_W'(issued_q) << $clog2(WORD_BYTES));
  assign w_accept     = (state_q == ST_IDLE) && start_i;
  assign w_pop        = dump_valid_o && dump_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = (word_count_i != '0) ? ST_READ : ST_DONE;
      ST_READ:  if (w_credit && w_last_issue) state_d = ST_DRAIN;
      // The last-tagged word is always the final one through the FIFO.
      ST_DRAIN: if (w_pop && dump_last_o) state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    done_o  = (state_q == ST_DONE);
    im_re_o = (state_q == ST_READ) && w_credit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      tag_vld_q  <= '0;
      tag_last_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_addr_q[i] <= '0;
    end else begin
      if (w_accept) begin
        base_q   <= base_addr_i & ~ADDR_W'(WORD_BYTES - 1);
        count_q  <= word_count_i;
        issued_q <= '0;
      end else if (im_re_o) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      tag_vld_q[0]  <= im_re_o;
      tag_last_q[0] <= im_re_o && w_last_issue;
      tag_addr_q[0] <= im_raddr_o;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1];
        tag_last_q[i] <= tag_last_q[i-1];
        tag_addr_q[i] <= tag_addr_q[i-1];
      end
    end
  end

  imem_dump_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tag_vld_q[RD_LAT-1]),
    .wdata_i ({tag_addr_q[RD_LAT-1], im_rdata_i, tag_last_q[RD_LAT-1]}),
    .pop_i   (w_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dump_valid_o = !fifo_empty;
  assign dump_addr_o  = fifo_rdata[FW-1 -: ADDR_W];
  assign dump_data_o  = fifo_rdata[DATA_W:1];
  assign dump_last_o  = fifo_rdata[0];

`ifdef IMEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum_q <= '0;
    else if (w_accept) csum_q <= '0;
    else if (w_pop)    csum_q <= csum_q + dump_data_o;
  end
  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_dump_reader.sv
// ============================================================================
// tb_imem_dump_reader : directed bench driving RD_LAT=1 and RD_LAT=2 instances in lockstep
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_dump_reader;
  import imem_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, ready;
  logic [31:0] base;
  logic [7:0]  wc;

  logic [1:0]  busy, done, im_re, dv, dl;
  logic [31:0] raddr [2];
  logic [31:0] rdata [2];
  logic [31:0] dd [2];
  logic [31:0] da [2];
  logic [31:0] cs [2];
  logic [31:0] pipe2;

  int n_chk = 0;
  int n_err = 0;

  int idx [2], dones [2], first_hs [2], last_hs [2], done_cyc [2];
  int busy_cyc [2], re_cnt [2], dv_cnt [2];
  int max_fc, stall;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h11;
  endfunction

  // IM models: one and two cycle read latency, poison value when idle
  always @(posedge clk) begin
    rdata[0] <= im_re[0] ? memval(raddr[0]) : 32'hDEADBEEF;
    pipe2    <= im_re[1] ? memval(raddr[1]) : 32'hDEADBEEF;
    rdata[1] <= pipe2;
  end

  imem_dump_reader #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .word_count_i(wc),
    .busy_o(busy[0]), .done_o(done[0]), .im_re_o(im_re[0]), .im_raddr_o(raddr[0]),
    .im_rdata_i(rdata[0]), .dump_valid_o(dv[0]), .dump_ready_i(ready),
    .dump_data_o(dd[0]), .dump_addr_o(da[0]), .dump_last_o(dl[0]), .checksum_o(cs[0])
  );

  imem_dump_reader #(.RD_LAT(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .start_i(start), .base_addr_i(base), .word_count_i(wc),
    .busy_o(busy[1]), .done_o(done[1]), .im_re_o(im_re[1]), .im_raddr_o(raddr[1]),
    .im_rdata_i(rdata[1]), .dump_valid_o(dv[1]), .dump_ready_i(ready),
    .dump_data_o(dd[1]), .dump_addr_o(da[1]), .dump_last_o(dl[1]), .checksum_o(cs[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tn);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_l%0d_busy", tn, k+1), 32'(busy[k]), 0);
      check($sformatf("%s_l%0d_done", tn, k+1), 32'(done[k]), 0);
      check($sformatf("%s_l%0d_im_re", tn, k+1), 32'(im_re[k]), 0);
      check($sformatf("%s_l%0d_valid", tn, k+1), 32'(dv[k]), 0);
      check($sformatf("%s_l%0d_data", tn, k+1), dd[k], 0);
      check($sformatf("%s_l%0d_addr", tn, k+1), da[k], 0);
      check($sformatf("%s_l%0d_last", tn, k+1), 32'(dl[k]), 0);
    end
  endtask

  // mode 0: ready held high; mode 1: ready toggles starting high.
  // restart_at >= 0 pulses start again at that cycle; abort_after > 0 resets
  // once the RD_LAT=1 instance has accepted that many words.
  task automatic run_dump(input string tn, input logic [31:0] b, input int cnt,
                          input int mode, input int restart_at, input int abort_after);
    logic [31:0] bb, ea;
    logic        pdv [2];
    logic [31:0] pdd [2], pda [2];
    logic        pdl [2];
    logic        prdy;
    int          tail;
    bit          aborted;
    bb = b & ~32'd3;
    tail = -1;
    aborted = 0;
    prdy = 1'b1;
    max_fc = 0;
    stall = 0;
    for (int k = 0; k < 2; k++) begin
      idx[k] = 0; dones[k] = 0; first_hs[k] = -1; last_hs[k] = -1; done_cyc[k] = -1;
      busy_cyc[k] = 0; re_cnt[k] = 0; dv_cnt[k] = 0; pdv[k] = 0;
      pdd[k] = 0; pda[k] = 0; pdl[k] = 0;
    end
    @(negedge clk);
    start = 1'b1; base = b; wc = 8'(cnt); ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      start = (cyc == restart_at);
      if (cyc == restart_at) begin base = ~b; wc = 8'(cnt + 5); end
      ready = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      if (abort_after > 0 && idx[0] == abort_after) begin
        rst_n = 1'b0;
        #1;
        check_idle({tn, "_abort"});
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check($sformatf("%s_abort_nodone%0d", tn, j), 32'(done), 0);
        end
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
      for (int k = 0; k < 2; k++) begin
        if (busy[k]) busy_cyc[k]++;
        if (im_re[k]) re_cnt[k]++;
        if (dv[k]) dv_cnt[k]++;
        if (pdv[k] && !prdy) begin
          check($sformatf("%s_l%0d_hold_valid", tn, k+1), 32'(dv[k]), 1);
          check($sformatf("%s_l%0d_hold_data", tn, k+1), dd[k], pdd[k]);
          check($sformatf("%s_l%0d_hold_addr", tn, k+1), da[k], pda[k]);
          check($sformatf("%s_l%0d_hold_last", tn, k+1), 32'(dl[k]), 32'(pdl[k]));
        end
        if (dv[k] && ready) begin
          if (idx[k] >= cnt) check($sformatf("%s_l%0d_extra_beat", tn, k+1), idx[k], cnt - 1);
          ea = bb + 32'(idx[k] * 4);
          check($sformatf("%s_l%0d_b%0d_addr", tn, k+1, idx[k]), da[k], ea);
          check($sformatf("%s_l%0d_b%0d_data", tn, k+1, idx[k]), dd[k], memval(ea));
          check($sformatf("%s_l%0d_b%0d_last", tn, k+1, idx[k]), 32'(dl[k]), 32'(idx[k] == cnt - 1));
          if (idx[k] == 0) first_hs[k] = cyc;
          last_hs[k] = cyc;
          idx[k]++;
        end
        if (done[k]) begin dones[k]++; done_cyc[k] = cyc; end
        pdv[k] = dv[k]; pdd[k] = dd[k]; pda[k] = da[k]; pdl[k] = dl[k];
      end
      prdy = ready;
      if (int'(u_dut_l2.u_fifo.count_o) > max_fc) max_fc = int'(u_dut_l2.u_fifo.count_o);
      if (u_dut_l2.state_q == ST_READ && !im_re[1]) stall++;
      if (tail < 0 && dones[0] > 0 && dones[1] > 0) tail = 4;
      if (tail > 0) tail--;
      if (tail == 0) break;
    end
    if (!aborted) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("%s_l%0d_beats", tn, k+1), idx[k], cnt);
        check($sformatf("%s_l%0d_done_pulses", tn, k+1), dones[k], 1);
        if (cnt > 0)
          check($sformatf("%s_l%0d_done_gap", tn, k+1), done_cyc[k] - last_hs[k], 1);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; base = '0; wc = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // 1: four words, ready high
    run_dump("t1", 32'h0, 4, 0, -1, 0);
    check("t1_l1_first_valid", first_hs[0], 2);
    check("t1_l2_first_valid", first_hs[1], 3);
    check("t1_l1_back_to_back", last_hs[0] - first_hs[0], 3);
    check("t1_l2_back_to_back", last_hs[1] - first_hs[1], 3);
`ifdef IMEM_DUMP_CHECKSUM_EN
    check("t1_l1_checksum", cs[0], 32'hAA);
    check("t1_l2_checksum", cs[1], 32'hAA);
`else
    check("t1_l1_checksum", cs[0], 32'h0);
    check("t1_l2_checksum", cs[1], 32'h0);
`endif

    // 2: eight words with ready toggling
    run_dump("t2", 32'h40, 8, 1, -1, 0);
    check("t2_fifo_max_le_depth", 32'(max_fc <= 4), 1);
    check("t2_credit_stall_seen", 32'(stall > 0), 1);

    // 3: zero-length dump
    run_dump("t3", 32'h80, 0, 0, -1, 0);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t3_l%0d_no_reads", k+1), re_cnt[k], 0);
      check($sformatf("t3_l%0d_busy_cycles", k+1), busy_cyc[k], 1);
      check($sformatf("t3_l%0d_no_valid", k+1), dv_cnt[k], 0);
    end

    // 4: address wrap past the top of the space
    run_dump("t4", 32'hFFFF_FFF8, 3, 0, -1, 0);

    // 5: reset mid-dump, then a clean rerun
    run_dump("t5a", 32'h100, 6, 0, -1, 2);
    run_dump("t5b", 32'h100, 6, 0, -1, 0);

    // 6: second start while busy is ignored
    run_dump("t6", 32'h200, 5, 0, 3, 0);
    check("t6_l1_reads", re_cnt[0], 5);
    check("t6_l2_reads", re_cnt[1], 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
